// File: rtl/cosmic_kb_pkg.sv
// Shared definitions for the key encoder: FSM states, key/note sizing and the
// priority encoder used to turn a key vector into a note number.
package cosmic_kb_pkg;

  localparam int unsigned NUM_KEYS = 7;
  localparam int unsigned NOTE_W   = 4;
  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld,
    StRelease
  } kb_state_e;

  // Highest set bit wins: bit NUM_KEYS-1 is note 1, bit 0 is note NUM_KEYS.
  function automatic logic [NOTE_W-1:0] encode_keys(input logic [NUM_KEYS-1:0] k);
    logic [NOTE_W-1:0] n;
    n = NOTE_NONE;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) n = NOTE_W'(NUM_KEYS - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_encoder_if.sv
// Key-switch input and accepted-note outputs of the key encoder.
interface key_encoder_if;
  import cosmic_kb_pkg::*;

  logic [NUM_KEYS-1:0] keys;
  logic [NOTE_W-1:0]   note;
  logic                note_valid;
  logic                note_release;
  logic                key_active;

  modport master (
    output keys,
    input  note,
    input  note_valid,
    input  note_release,
    input  key_active
  );

  modport slave (
    input  keys,
    output note,
    output note_valid,
    output note_release,
    output key_active
  );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous key inputs, synchronous active-high reset.
module key_sync #(
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_encoder.sv
// Debounced key-to-note encoder: synchronizes the keys, priority-encodes them and
// accepts/releases a note only after it has been stable for DEBOUNCE_CYCLES clocks.
module key_encoder
  import cosmic_kb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  key_encoder_if.slave  bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] keys_sync;
  logic [NOTE_W-1:0]   enc;

  kb_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NOTE_W-1:0] cand_q, cand_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              valid_q, valid_d;
  logic              release_q, release_d;
  logic              active_q, active_d;

  key_sync #(
    .Width(NUM_KEYS)
  ) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.keys),
    .q   (keys_sync)
  );

  assign enc = encode_keys(keys_sync);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    note_d    = note_q;
    valid_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enc != NOTE_NONE) begin
          cand_d  = enc;
          cnt_d   = '0;
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (enc != cand_q) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          note_d  = cand_q;
          valid_d = 1'b1;
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (enc != note_q) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        // Key came back before the release window expired: silently resume.
        if (enc == note_q) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          cnt_d     = '0;
          note_d    = NOTE_NONE;
          release_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    active_d = (state_d == StHeld) || (state_d == StRelease);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cand_q    <= NOTE_NONE;
      note_q    <= NOTE_NONE;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      release_q <= release_d;
      active_q  <= active_d;
    end
  end

  assign bus.note         = note_q;
  assign bus.note_valid   = valid_q;
  assign bus.note_release = release_q;
  assign bus.key_active   = active_q;

endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder: a timestamp-based reference model predicts
// per-edge output levels and note accept/release events; a monitor compares them.
module tb_key_encoder;
  import cosmic_kb_pkg::*;

  localparam int unsigned Deb = 4;

  logic clk = 1'b1;
  logic rst = 1'b1;

  key_encoder_if kb();

  key_encoder #(
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kb.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_n;
    bit is_release;
    int note;
  } event_t;

  typedef struct {
    int note;
    bit valid;
    bit rel;
    bit active;
  } level_t;

  event_t ev_q[$];
  level_t lvl_q[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Reference model: keys reach the encoder two edges late; a note is accepted
  // once the same nonzero value has been seen for Deb edges after first being
  // noticed, and released once a different value has persisted equally long.
  int m_note = 0;
  int m_cand = 0;
  int m_start = 0;
  bit m_pend = 0;
  bit m_leave = 0;
  int hist[$] = {0, 0};

  function automatic int ref_encode(input int k);
    for (int n = 1; n <= 7; n++) begin
      if (k[7-n]) return n;
    end
    return 0;
  endfunction

  task automatic model_step(input int k, input bit r);
    int e;
    int edge_n;
    level_t l;
    edge_n = cyc + 1;
    l.valid = 1'b0;
    l.rel = 1'b0;
    if (r) begin
      hist = {0, 0};
      m_note = 0;
      m_pend = 0;
      m_leave = 0;
    end else begin
      e = ref_encode(hist[0]);
      void'(hist.pop_front());
      hist.push_back(k);
      if (m_note == 0) begin
        if (!m_pend) begin
          if (e != 0) begin
            m_pend = 1;
            m_cand = e;
            m_start = edge_n;
          end
        end else if (e != m_cand) begin
          m_pend = 0;
        end else if (edge_n - m_start == Deb) begin
          m_note = m_cand;
          m_pend = 0;
          l.valid = 1'b1;
          ev_q.push_back('{edge_n: edge_n, is_release: 1'b0, note: m_note});
        end
      end else begin
        if (!m_leave) begin
          if (e != m_note) begin
            m_leave = 1;
            m_start = edge_n;
          end
        end else if (e == m_note) begin
          m_leave = 0;
        end else if (edge_n - m_start == Deb) begin
          m_note = 0;
          m_leave = 0;
          l.rel = 1'b1;
          ev_q.push_back('{edge_n: edge_n, is_release: 1'b1, note: 0});
        end
      end
    end
    l.note = m_note;
    l.active = (m_note != 0);
    lvl_q.push_back(l);
  endtask

  task automatic step(input int k, input bit r, input int n);
    repeat (n) begin
      @(negedge clk);
      kb.keys = 7'(k);
      rst = r;
      model_step(k, r);
    end
  endtask

  level_t mon_l;
  event_t mon_e;

  always @(posedge clk) begin
    #1;
    if (lvl_q.size() > 0) begin
      mon_l = lvl_q.pop_front();
      chk("note", int'(kb.note), mon_l.note);
      chk("key_active", int'(kb.key_active), int'(mon_l.active));
      chk("note_valid", int'(kb.note_valid), int'(mon_l.valid));
      chk("note_release", int'(kb.note_release), int'(mon_l.rel));
    end
    if (kb.note_valid === 1'b1 || kb.note_release === 1'b1) begin
      chk("pulse_overlap", int'(kb.note_valid && kb.note_release), 0);
      if (ev_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = ev_q.pop_front();
        chk("pulse_edge", cyc, mon_e.edge_n);
        chk("pulse_kind", int'(kb.note_release), int'(mon_e.is_release));
        chk("pulse_note", int'(kb.note), mon_e.note);
      end
    end
  end

  initial begin
    int sel;
    int k;
    kb.keys = '0;
    // Reset with every key pressed, then a short press after release.
    step(7'h7f, 1'b1, 3);
    step(7'h7f, 1'b0, 2);
    step(7'h00, 1'b0, 8);
    // Note 3 held long, then released.
    step(7'b0010000, 1'b0, 20);
    step(7'h00, 1'b0, 12);
    // Bounce shorter than the debounce window.
    step(7'b0000001, 1'b0, 2);
    step(7'h00, 1'b0, 10);
    // Two keys: the higher one wins.
    step(7'b0100001, 1'b0, 15);
    step(7'h00, 1'b0, 12);
    // Direct switch from note 1 to note 5.
    step(7'b1000000, 1'b0, 10);
    step(7'b0000100, 1'b0, 15);
    step(7'h00, 1'b0, 12);
    // Reset while holding note 4; key stays pressed across it.
    step(7'b0001000, 1'b0, 10);
    step(7'b0001000, 1'b1, 1);
    step(7'b0001000, 1'b0, 10);
    step(7'h00, 1'b0, 12);
    // Random key activity with occasional resets.
    for (int s = 0; s < 80; s++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3) k = 0;
      else if (sel < 8) k = 1 << $urandom_range(0, 6);
      else k = int'($urandom_range(1, 127));
      step(k, 1'b0, int'($urandom_range(1, 9)));
      if ($urandom_range(0, 29) == 0) step(k, 1'b1, 1);
    end
    step(7'h00, 1'b0, 14);
    @(posedge clk);
    #2;
    chk("events_drained", ev_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_encoder.md
KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of clocks an encoded key value must stay stable to be accepted (10 ms at 100 MHz); legal range >= 2.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 keys  input  7  raw asynchronous key switches; bit 6 = note 1 ... bit 0 = note 7; 1 = pressed.
REQ-005 note  output  4  accepted note number 1..7; 0 = no note.
REQ-006 note_valid  output  1  one-cycle pulse when a new note is accepted.
REQ-007 note_release  output  1  one-cycle pulse when the held note is released.
REQ-008 key_active  output  1  high while state is HELD or RELEASE.

Function
REQ-009 keys SHALL pass through a 2-flop synchronizer; all downstream logic uses the synchronized value only.
REQ-010 Encoded value enc SHALL be combinational from synchronized keys: the highest set bit wins (bit 6 -> 1, bit 0 -> 7); no bits set -> 0.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, HELD, RELEASE; a counter of width clog2(DEBOUNCE_CYCLES) is shared by DEBOUNCE and RELEASE.
REQ-012 IDLE: enc != 0 -> capture cand = enc, clear counter, go DEBOUNCE; otherwise stay.
REQ-013 DEBOUNCE: enc != cand -> go IDLE, clear counter; else if counter == DEBOUNCE_CYCLES-1 -> go HELD, note <= cand, note_valid = 1 for one cycle; else counter++.
REQ-014 HELD: enc == note -> stay; enc != note (including 0 or a different key) -> go RELEASE, clear counter.
REQ-015 RELEASE: enc == note -> go HELD, clear counter, no pulse; else if counter == DEBOUNCE_CYCLES-1 -> go IDLE, note <= 0, note_release = 1 for one cycle; else counter++.
REQ-016 Latency: a keys change held stable from cycle 0 SHALL produce note_valid (and the new note value) registered at rising edge DEBOUNCE_CYCLES+3; release behaves the same for note_release.
REQ-017 A direct switch from note A to note B SHALL produce note_release for A, then at least one IDLE cycle, then note_valid for B; note_valid and note_release SHALL never be high in the same cycle.
REQ-018 All outputs SHALL be registered; note SHALL change only on the note_valid or note_release cycle.
REQ-019 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 only at the transition point.

Reset
REQ-020 On rst high at a clock edge: state = IDLE, counter = 0, cand = 0, synchronizer flops = 0, note = 0, note_valid = 0, note_release = 0, key_active = 0.
REQ-021 Reset asserted mid-DEBOUNCE, mid-HELD or mid-RELEASE SHALL abort without emitting any pulse; after deassertion a still-pressed key is re-debounced from the start.

Structure
REQ-022 Shared package cosmic_kb_pkg SHALL hold the FSM state enum, NOTE_NONE = 0, NUM_KEYS = 7 and the note-width constant 4.
REQ-023 The synchronizer SHALL be a separate sub-module key_sync (parameterized width, 2 flops, synchronous reset); the priority encoder and FSM live in key_encoder.

Verification (DEBOUNCE_CYCLES = 4)
REQ-024 Hold rst for 3 cycles with keys = 7'b1111111 -> all outputs 0 throughout and on the first cycle after release of rst.
REQ-025 keys = 7'b0010000 held for 20 cycles, then 0 -> note_valid pulses once at edge 7 with note = 3; note_release pulses once 7 edges after release, with note = 0 from then on.
REQ-026 keys = 7'b0000001 for 2 cycles, then 0 (bounce) -> no note_valid; state returns to IDLE; note stays 0.
REQ-027 keys = 7'b0100001 held -> note = 2 and exactly one note_valid.
REQ-028 keys = 7'b1000000 held until accepted, then switched directly to 7'b0000100 -> note_release with note 1 -> 0, then note_valid with note = 5; the two pulses never overlap.
REQ-029 rst asserted for 1 cycle while HELD on note 4 with the key still pressed -> note = 0 and no pulse on the reset edge; note_valid with note = 4 occurs again 7 edges after rst deasserts.
